// File: rtl/bist_pkg.sv
// Shared definitions for the BIST session controller: state encoding and counter sizing.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } bist_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bist_clk_div.sv
// Modulo-DIV counter with synchronous clear; tc flags the last count of each period.
// Latency: tc is combinational from the count register, valid in the same cycle.
// Backpressure: none; advances whenever en is high and clr is low.
module bist_clk_div
    import bist_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_w(DIV);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == W'(DIV - 1)) ? '0 : cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(DIV - 1));

endmodule

// File: rtl/bist_ctrl_param.sv
// BIST session controller: NPASS passes of init / NCLOCK run / finish; optional abort under BIST_ABORT_EN.
// Latency: init one cycle after start is sampled; bist_end NPASS*(NCLOCK+2) cycles after it.
// Backpressure: none; start is ignored while a session is in progress.
module bist_ctrl_param
    import bist_pkg::*;
#(
    parameter int NCLOCK     = 650,
    parameter int NPASS      = 1,
    parameter int TOGGLE_DIV = 1,
    localparam int PASS_W    = cnt_w(NPASS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef BIST_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              init,
    output logic              running,
    output logic              toggle,
    output logic              finish,
    output logic              bist_end,
    output logic [PASS_W-1:0] pass_idx
);

    localparam int CNT_W = cnt_w(NCLOCK);

    bist_state_t       state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              div_en;
    logic              div_clr;
    logic              div_tc;
    logic              last_run;
    logic              last_pass;
    logic              abort_hit;

    // The divider runs one cycle ahead of the RUN cycle it describes, so its
    // terminal count can be registered straight into toggle.
    assign div_en  = (state == ST_INIT) || (state == ST_RUN);
    assign div_clr = !div_en;

    bist_clk_div #(
        .DIV (TOGGLE_DIV)
    ) u_div (
        .clk (clk),
        .rst (reset),
        .clr (div_clr),
        .en  (div_en),
        .tc  (div_tc)
    );

    assign last_run  = (cyc_cnt == CNT_W'(NCLOCK - 1));
    assign last_pass = (pass_idx == PASS_W'(NPASS - 1));

`ifdef BIST_ABORT_EN
    assign abort_hit = abort && ((state == ST_INIT) || (state == ST_RUN) || (state == ST_FIN));
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cyc_cnt  <= '0;
            pass_idx <= '0;
            init     <= 1'b0;
            running  <= 1'b0;
            toggle   <= 1'b0;
            finish   <= 1'b0;
            bist_end <= 1'b0;
`ifdef BIST_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            init   <= 1'b0;
            toggle <= 1'b0;
            finish <= 1'b0;
            if (abort_hit) begin
                // Abort beats the terminal count: straight to DONE, no finish pulse.
                state    <= ST_DONE;
                running  <= 1'b0;
                bist_end <= 1'b1;
`ifdef BIST_ABORT_EN
                aborted  <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state    <= ST_INIT;
                            init     <= 1'b1;
                            pass_idx <= '0;
                            bist_end <= 1'b0;
`ifdef BIST_ABORT_EN
                            aborted  <= 1'b0;
`endif
                        end
                    end
                    ST_INIT: begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        cyc_cnt <= '0;
                        toggle  <= div_tc;
                    end
                    ST_RUN: begin
                        if (last_run) begin
                            state   <= ST_FIN;
                            running <= 1'b0;
                            finish  <= 1'b1;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                            toggle  <= div_tc;
                        end
                    end
                    ST_FIN: begin
                        if (last_pass) begin
                            state    <= ST_DONE;
                            bist_end <= 1'b1;
                        end else begin
                            state    <= ST_INIT;
                            init     <= 1'b1;
                            pass_idx <= pass_idx + PASS_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Scoreboard bench for bist_ctrl_param: expected output events queued at stimulus time, popped by a monitor.
module tb_bist_ctrl_param;

    localparam int NCLOCK     = 650;
    localparam int NPASS      = 3;
    localparam int TOGGLE_DIV = 7;
    localparam int PASS_W     = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int SESS       = NPASS * (NCLOCK + 2);

    localparam int EV_INIT = 0;
    localparam int EV_TOG  = 1;
    localparam int EV_FIN  = 2;
    localparam int EV_END  = 3;

    typedef struct {
        int kind;
        int cyc;
        int pidx;
        int x;
    } ev_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              init;
    logic              running;
    logic              toggle;
    logic              finish;
    logic              bist_end;
    logic [PASS_W-1:0] pass_idx;
`ifdef BIST_ABORT_EN
    logic              abort;
    logic              aborted;
    logic              abort_nxt;
`endif

    bist_ctrl_param #(
        .NCLOCK     (NCLOCK),
        .NPASS      (NPASS),
        .TOGGLE_DIV (TOGGLE_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef BIST_ABORT_EN
        .abort    (abort),
        .aborted  (aborted),
`endif
        .init     (init),
        .running  (running),
        .toggle   (toggle),
        .finish   (finish),
        .bist_end (bist_end),
        .pass_idx (pass_idx)
    );

    ev_t exp_q[$];
    int  cyc       = 0;
    int  n_chk     = 0;
    int  n_pass    = 0;
    int  idle_from = 0;
    int  sess_start = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void push_ev(input int kind, input int c, input int p, input int x);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.pidx = p;
        e.x    = x;
        exp_q.push_back(e);
    endfunction

    // Reference: a session accepted at edge k is a fixed timetable of output events.
    function automatic void push_session(input int k);
        for (int p = 0; p < NPASS; p++) begin
            int b;
            b = k + p * (NCLOCK + 2);
            push_ev(EV_INIT, b, p, 0);
            for (int i = 0; i < NCLOCK; i++) begin
                if (i % TOGGLE_DIV == TOGGLE_DIV - 1)
                    push_ev(EV_TOG, b + 1 + i, p, 0);
            end
            push_ev(EV_FIN, b + NCLOCK + 1, p, NCLOCK);
        end
        push_ev(EV_END, k + SESS, NPASS - 1, 0);
    endfunction

    function automatic void flush_from(input int lim);
        while (exp_q.size() > 0 && exp_q[$].cyc >= lim)
            void'(exp_q.pop_back());
    endfunction

    task automatic observe(input int kind, input int p, input int x);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL event: unexpected kind=%0d pidx=%0d x=%0d at cycle %0d, required none", kind, p, x, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.pidx == p && e.x == x)
                n_pass++;
            else
                $display("FAIL event: got kind=%0d cyc=%0d pidx=%0d x=%0d, required kind=%0d cyc=%0d pidx=%0d x=%0d",
                         kind, cyc, p, x, e.kind, e.cyc, e.pidx, e.x);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and turns pulses into events.
    initial begin
        int  run_cnt;
        logic prev_be;
        int  ab;
        run_cnt = 0;
        prev_be = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            ab = 0;
`ifdef BIST_ABORT_EN
            ab = int'(aborted);
`endif
            if (init) begin
                run_cnt = 0;
                observe(EV_INIT, int'(pass_idx), ab);
            end
            if (running)
                run_cnt++;
            if (toggle)
                observe(EV_TOG, int'(pass_idx), 0);
            if (finish)
                observe(EV_FIN, int'(pass_idx), run_cnt);
            if (bist_end && !prev_be)
                observe(EV_END, int'(pass_idx), ab);
            prev_be = bist_end;
        end
    end

    // One cycle of stimulus, applied at the falling edge; the model decides what edge k does.
    task automatic step(input logic s, input logic r);
        int k;
        logic prev_r;
        @(negedge clk);
        prev_r = reset;
        start  = s;
        reset  = r;
`ifdef BIST_ABORT_EN
        abort     = abort_nxt;
        abort_nxt = 1'b0;
`endif
        k = cyc + 1;
        if (r) begin
            if (!prev_r)
                flush_from(k);
            idle_from  = 0;
            sess_start = -1;
            #1;
            n_chk++;
            if ({init, running, toggle, finish, bist_end} == 5'b0 && pass_idx == '0
`ifdef BIST_ABORT_EN
                && !aborted
`endif
               )
                n_pass++;
            else
                $display("FAIL reset_outputs: got init=%b running=%b toggle=%b finish=%b bist_end=%b pass_idx=%0d, required all 0",
                         init, running, toggle, finish, bist_end, pass_idx);
        end else if (s && k >= idle_from) begin
            push_session(k);
            sess_start = k;
            idle_from  = k + SESS + 1;
        end
`ifdef BIST_ABORT_EN
        else if (abort && k > sess_start && k < idle_from) begin
            flush_from(k);
            push_ev(EV_END, k, (k - sess_start - 1) / (NCLOCK + 2), 1);
            idle_from = k + 1;
        end
`endif
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    initial begin
        int wait_cyc;
        start = 1'b0;
        reset = 1'b1;
`ifdef BIST_ABORT_EN
        abort     = 1'b0;
        abort_nxt = 1'b0;
`endif
        repeat (3) step(1'b0, 1'b1);
        run_idle(3);

        // Single pulse, then a start 30 cycles into RUN that must be ignored.
        step(1'b1, 1'b0);
        run_idle(32);
        step(1'b1, 1'b0);
        run_idle(SESS + 5);

        // Restart from DONE, start held for several cycles.
        repeat (4) step(1'b1, 1'b0);
        run_idle(SESS + 3);

        // Reset mid-RUN, reset and start together, then release with start held.
        step(1'b1, 1'b0);
        run_idle(200);
        repeat (2) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        run_idle(SESS + 5);

`ifdef BIST_ABORT_EN
        // Abort at RUN cycle ~100 of pass 1, then a fresh start.
        step(1'b1, 1'b0);
        run_idle(NCLOCK + 2 + 101);
        abort_nxt = 1'b1;
        run_idle(5);
        step(1'b1, 1'b0);
        run_idle(SESS + 5);
`endif

        for (int seg = 0; seg < 12; seg++) begin
            if ($urandom_range(0, 9) < 2) begin
                repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                repeat ($urandom_range(1, 4)) step(1'b1, 1'b0);
            end
            repeat ($urandom_range(100, 2200)) begin
`ifdef BIST_ABORT_EN
                abort_nxt = ($urandom_range(0, 799) == 0);
`endif
                step(($urandom_range(0, 299) == 0), 1'b0);
            end
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < SESS + 100) begin
            step(1'b0, 1'b0);
            wait_cyc++;
        end
        n_chk++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: %0d expected events still pending (next cyc=%0d kind=%0d), required 0",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].kind);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
